fpnew_slice_result_collector: RTL and testbench

Downstream end of the format-slice output handshake. Takes result/status/tag streams from NumSlices format slices of one operation group and arbitrates them round-robin into a single registered output port. Accumulates sticky IEEE status flags from retired results and counts retirements. Sits between the per-format slices and the FPU top-level output arbiter.

---
 rtl/fpnew_slice_result_collector.sv | 153 +++++++++++++++
 tb/tb_fpnew_slice_result_collector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_slice_result_collector.sv
// Round-robin collector of format-slice results into one registered port.
// Ports: slice_* in/ready out, flush_i, result/status/ext/tag/src out with
// out_valid_o/out_ready_i, sticky flags_o, retired_cnt_o and busy_o.
module fpnew_slice_result_collector #(
  parameter int unsigned NumSlices = 4,
  parameter int unsigned Width     = 64,
  parameter int unsigned TagWidth  = 8,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned SrcWidth = $clog2(NumSlices)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumSlices*Width-1:0]    slice_result_i,
  input  logic [NumSlices*5-1:0]        slice_status_i,
  input  logic [NumSlices-1:0]          slice_ext_bit_i,
  input  logic [NumSlices*TagWidth-1:0] slice_tag_i,
  input  logic [NumSlices-1:0]          slice_valid_i,
  output logic [NumSlices-1:0]          slice_ready_o,
  input  logic                          flush_i,
  output logic [Width-1:0]              result_o,
  output logic [4:0]                    status_o,
  output logic                          extension_bit_o,
  output logic [TagWidth-1:0]           tag_o,
  output logic [SrcWidth-1:0]           src_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [4:0]                    flags_o,
  input  logic                          flags_clr_i,
  output logic [CntWidth-1:0]           retired_cnt_o,
  output logic                          busy_o
);

  localparam logic [SrcWidth:0] NS = (SrcWidth+1)'(NumSlices);
  localparam logic [SrcWidth-1:0] LAST =
    SrcWidth'(NumSlices - 1);

  logic [Width-1:0]    res_a [NumSlices];
  logic [4:0]          st_a  [NumSlices];
  logic [TagWidth-1:0] tag_a [NumSlices];

  logic [SrcWidth-1:0] ptr_q, ptr_d;
  logic [SrcWidth-1:0] gnt_idx;
  logic                gnt_vld;
  logic                can_load;
  logic                accept;
  logic                retire;

  logic [Width-1:0]    res_q;
  logic [4:0]          st_q;
  logic                ext_q;
  logic [TagWidth-1:0] tag_q;
  logic [SrcWidth-1:0] src_q;
  logic                vld_q;
  logic [4:0]          flags_q, flags_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int k = 0; k < NumSlices; k++) begin
      res_a[k] = slice_result_i[k*Width +: Width];
      st_a[k]  = slice_status_i[k*5 +: 5];
      tag_a[k] = slice_tag_i[k*TagWidth +: TagWidth];
    end
  end

  // First valid slice at or after the pointer, wrapping around.
  always_comb begin
    logic [SrcWidth:0]   sum;
    logic [SrcWidth-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NumSlices; i++) begin
      sum = {1'b0, ptr_q} + (SrcWidth+1)'(i);
      if (sum >= NS) sum = sum - NS;
      idx = sum[SrcWidth-1:0];
      if (!gnt_vld && slice_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign can_load = (!vld_q | out_ready_i) & !flush_i & !rst_i;
  assign accept   = gnt_vld & can_load;
  assign retire   = vld_q & out_ready_i & !flush_i;

  always_comb begin
    slice_ready_o = '0;
    if (accept) slice_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + SrcWidth'(1);
    end
  end

  // A clear coinciding with a retire keeps only the new status.
  always_comb begin
    flags_d = flags_q;
    if (retire) begin
      flags_d = (flags_clr_i ? 5'd0 : flags_q) | st_q;
    end else if (flags_clr_i) begin
      flags_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire && cnt_q != '1) cnt_d = cnt_q + CntWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q   <= '0;
      st_q    <= '0;
      ext_q   <= 1'b0;
      tag_q   <= '0;
      src_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        res_q <= res_a[gnt_idx];
        st_q  <= st_a[gnt_idx];
        ext_q <= slice_ext_bit_i[gnt_idx];
        tag_q <= tag_a[gnt_idx];
        src_q <= gnt_idx;
        vld_q <= 1'b1;
      end else if (flush_i || retire) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign result_o        = res_q;
  assign status_o        = st_q;
  assign extension_bit_o = ext_q;
  assign tag_o           = tag_q;
  assign src_o           = src_q;
  assign out_valid_o     = vld_q;
  assign flags_o         = flags_q;
  assign retired_cnt_o   = cnt_q;
  assign busy_o          = vld_q | (|slice_valid_i);

endmodule

// File: tb/tb_fpnew_slice_result_collector.sv
// Scoreboard bench for fpnew_slice_result_collector.
// Directed vectors; monitor pops expected results on each output retire.
module tb_fpnew_slice_result_collector;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TW = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N*W-1:0]  slice_result_i;
  logic [N*5-1:0]  slice_status_i;
  logic [N-1:0]    slice_ext_bit_i;
  logic [N*TW-1:0] slice_tag_i;
  logic [N-1:0]    slice_valid_i;
  logic [N-1:0]    slice_ready_o;
  logic            flush_i;
  logic [W-1:0]    result_o;
  logic [4:0]      status_o;
  logic            extension_bit_o;
  logic [TW-1:0]   tag_o;
  logic [1:0]      src_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [4:0]      flags_o;
  logic            flags_clr_i;
  logic [CW-1:0]   retired_cnt_o;
  logic            busy_o;

  fpnew_slice_result_collector #(
    .NumSlices(N), .Width(W), .TagWidth(TW), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .slice_result_i(slice_result_i),
    .slice_status_i(slice_status_i),
    .slice_ext_bit_i(slice_ext_bit_i),
    .slice_tag_i(slice_tag_i),
    .slice_valid_i(slice_valid_i),
    .slice_ready_o(slice_ready_o),
    .flush_i(flush_i),
    .result_o(result_o),
    .status_o(status_o),
    .extension_bit_o(extension_bit_o),
    .tag_o(tag_o),
    .src_o(src_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .flags_o(flags_o),
    .flags_clr_i(flags_clr_i),
    .retired_cnt_o(retired_cnt_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef logic [79:0] ent_t;
  ent_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] r, input logic [4:0] s,
                              input logic e, input logic [7:0] t,
                              input logic [1:0] src);
    return {r, s, e, t, src};
  endfunction

  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", 80'd1, 80'd0);
      end else begin
        chk("out_entry",
            {result_o, status_o, extension_bit_o, tag_o, src_o},
            exp_q.pop_front());
      end
    end
  end

  task automatic set_slice(input int s, input logic [63:0] r,
                           input logic [4:0] st, input logic e,
                           input logic [7:0] t, input logic v);
    slice_result_i[s*W +: W]   = r;
    slice_status_i[s*5 +: 5]   = st;
    slice_ext_bit_i[s]         = e;
    slice_tag_i[s*TW +: TW]    = t;
    slice_valid_i[s]           = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    slice_valid_i = '0;
    flush_i       = 1'b0;
    flags_clr_i   = 1'b0;
    out_ready_i   = 1'b0;
    step();
    step();
    chk("rst_state",
        {out_valid_o, flags_o, 2'(retired_cnt_o), result_o,
         status_o, tag_o, src_o},
        80'd0);
    rst_i = 1'b0;
  endtask

  initial begin
    slice_result_i  = '0;
    slice_status_i  = '0;
    slice_ext_bit_i = '0;
    slice_tag_i     = '0;
    do_reset();
    chk("idle_busy", 80'(busy_o), 80'd0);

    // Slices 0 and 2 valid.
    out_ready_i = 1'b1;
    set_slice(0, 64'h1111, 5'h00, 1'b1, 8'h10, 1'b1);
    set_slice(2, 64'h2222, 5'h00, 1'b0, 8'h12, 1'b1);
    exp_q.push_back(mk(64'h1111, 5'h00, 1'b1, 8'h10, 2'd0));
    exp_q.push_back(mk(64'h2222, 5'h00, 1'b0, 8'h12, 2'd2));
    #1;
    chk("A_rdy0", 80'(slice_ready_o), 80'b0001);
    chk("A_busy", 80'(busy_o), 80'd1);
    step();
    slice_valid_i[0] = 1'b0;
    chk("A_c1", {out_valid_o, src_o, slice_ready_o},
        {1'b1, 2'd0, 4'b0100});
    step();
    slice_valid_i[2] = 1'b0;
    chk("A_c2", {out_valid_o, src_o}, {1'b1, 2'd2});
    step();
    chk("A_cnt", {out_valid_o, 2'(retired_cnt_o)}, {1'b0, 2'd2});

    // All slices valid: full throughput 0,1,2,3,0; counter saturates.
    do_reset();
    out_ready_i = 1'b1;
    set_slice(0, 64'hA0, 5'h00, 1'b0, 8'hA0, 1'b1);
    set_slice(1, 64'hA1, 5'h00, 1'b1, 8'hA1, 1'b1);
    set_slice(2, 64'hA2, 5'h00, 1'b0, 8'hA2, 1'b1);
    set_slice(3, 64'hA3, 5'h00, 1'b1, 8'hA3, 1'b1);
    exp_q.push_back(mk(64'hA0, 5'h00, 1'b0, 8'hA0, 2'd0));
    exp_q.push_back(mk(64'hA1, 5'h00, 1'b1, 8'hA1, 2'd1));
    exp_q.push_back(mk(64'hA2, 5'h00, 1'b0, 8'hA2, 2'd2));
    exp_q.push_back(mk(64'hA3, 5'h00, 1'b1, 8'hA3, 2'd3));
    exp_q.push_back(mk(64'hA0, 5'h00, 1'b0, 8'hA0, 2'd0));
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 4) slice_valid_i = '0;
      chk($sformatf("B_src%0d", k), {out_valid_o, src_o},
          {1'b1, 2'(k % 4)});
    end
    step();
    chk("B_sat", {out_valid_o, 2'(retired_cnt_o)}, {1'b0, 2'd3});

    // Backpressure for 3 cycles.
    do_reset();
    set_slice(1, 64'h5A5A, 5'h00, 1'b1, 8'h5A, 1'b1);
    #1;
    chk("C_rdy", 80'(slice_ready_o), 80'b0010);
    step();
    slice_valid_i[1] = 1'b0;
    set_slice(3, 64'h7777, 5'h00, 1'b0, 8'h77, 1'b1);
    exp_q.push_back(mk(64'h5A5A, 5'h00, 1'b1, 8'h5A, 2'd1));
    exp_q.push_back(mk(64'h7777, 5'h00, 1'b0, 8'h77, 2'd3));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("C_hold%0d", k),
          {slice_ready_o, tag_o, result_o},
          {4'b0000, 8'h5A, 64'h5A5A});
      step();
    end
    out_ready_i = 1'b1;
    #1;
    chk("C_rel_rdy", 80'(slice_ready_o), 80'b1000);
    step();
    slice_valid_i[3] = 1'b0;
    chk("C_next", {out_valid_o, tag_o}, {1'b1, 8'h77});
    step();
    chk("C_cnt", 80'(retired_cnt_o), 80'd2);

    // Sticky flags and clear.
    do_reset();
    out_ready_i = 1'b1;
    set_slice(0, 64'hD0, 5'h01, 1'b0, 8'hD0, 1'b1);
    exp_q.push_back(mk(64'hD0, 5'h01, 1'b0, 8'hD0, 2'd0));
    step();
    slice_valid_i[0] = 1'b0;
    set_slice(1, 64'hD1, 5'h10, 1'b0, 8'hD1, 1'b1);
    exp_q.push_back(mk(64'hD1, 5'h10, 1'b0, 8'hD1, 2'd1));
    step();
    slice_valid_i[1] = 1'b0;
    set_slice(2, 64'hD2, 5'h04, 1'b1, 8'hD2, 1'b1);
    exp_q.push_back(mk(64'hD2, 5'h04, 1'b1, 8'hD2, 2'd2));
    step();
    slice_valid_i[2] = 1'b0;
    chk("D_or", 80'(flags_o), 80'h11);
    flags_clr_i = 1'b1;
    step();
    chk("D_clr_ret", 80'(flags_o), 80'h04);
    step();
    chk("D_clr", 80'(flags_o), 80'h00);
    flags_clr_i = 1'b0;

    // Flush of a buffered result.
    do_reset();
    set_slice(0, 64'hF0, 5'h02, 1'b0, 8'hE0, 1'b1);
    step();
    slice_valid_i[0] = 1'b0;
    set_slice(1, 64'hE1, 5'h00, 1'b0, 8'hE1, 1'b1);
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    #1;
    chk("E_rdy", 80'(slice_ready_o), 80'b0000);
    step();
    flush_i = 1'b0;
    chk("E_after",
        {out_valid_o, 2'(retired_cnt_o), flags_o, result_o},
        {1'b0, 2'd0, 5'h00, 64'hF0});
    #1;
    chk("E_rdy2", 80'(slice_ready_o), 80'b0010);
    exp_q.push_back(mk(64'hE1, 5'h00, 1'b0, 8'hE1, 2'd1));
    step();
    slice_valid_i[1] = 1'b0;
    step();
    chk("E_cnt", {out_valid_o, 2'(retired_cnt_o)}, {1'b0, 2'd1});

    // Reset in the middle of traffic.
    set_slice(2, 64'hC2, 5'h08, 1'b0, 8'hC2, 1'b1);
    exp_q.push_back(mk(64'hC2, 5'h08, 1'b0, 8'hC2, 2'd2));
    step();
    slice_valid_i[2] = 1'b0;
    step();
    chk("F_pre", {flags_o, 2'(retired_cnt_o)}, {5'h08, 2'd2});
    out_ready_i = 1'b0;
    set_slice(1, 64'hC1, 5'h00, 1'b0, 8'hC1, 1'b1);
    set_slice(3, 64'hC3, 5'h00, 1'b0, 8'hC3, 1'b1);
    step();
    chk("F_buf", {out_valid_o, src_o}, {1'b1, 2'd3});
    rst_i = 1'b1;
    #1;
    chk("F_rst_rdy", 80'(slice_ready_o), 80'b0000);
    step();
    chk("F_rst",
        {out_valid_o, flags_o, 2'(retired_cnt_o)}, 80'd0);
    rst_i = 1'b0;
    #1;
    chk("F_gnt1", 80'(slice_ready_o), 80'b0010);
    slice_valid_i[0] = 1'b1;
    #1;
    chk("F_gnt0", 80'(slice_ready_o), 80'b0001);
    slice_valid_i = '0;
    step();
    step();
    chk("drain", 80'(exp_q.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
